// File: rtl/seq_pkg.sv
// Shared types for the core sequencer: state encodings and trap causes.
package seq_pkg;

    // Encodings are visible on LEDR, so values are fixed explicitly.
    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StFetch     = 4'd1,
        StFetchWait = 4'd2,
        StDecode    = 4'd3,
        StExecute   = 4'd4,
        StMem       = 4'd5,
        StMemWait   = 4'd6,
        StWriteback = 4'd7,
        StStepPause = 4'd8,
        StHalted    = 4'd9,
        StTrap      = 4'd15
    } state_e;

    typedef enum logic [2:0] {
        CauseNone         = 3'd0,
        CauseDecode       = 3'd1,
        CauseMemFault     = 3'd2,
        CauseFetchTimeout = 3'd3,
        CauseDataTimeout  = 3'd4,
        CauseIllegalState = 3'd5
    } trap_cause_e;

    localparam int unsigned TimeoutWidth = 16;

    // States in which the core is running and the cycle counter advances.
    function automatic logic is_active(state_e s);
        return !(s inside {StIdle, StHalted, StTrap});
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts memory wait cycles without an acknowledge and flags expiry.
module mem_timeout_counter
    import seq_pkg::*;
#(
    parameter int unsigned Width = TimeoutWidth
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [Width-1:0] limit_i,
    output logic             expired_o
);

    logic [Width-1:0] count_q;
    logic [Width:0]   count_inc;

    // Expiry fires on the enabled cycle that would bring the count up to the limit.
    assign count_inc = {1'b0, count_q} + {{Width{1'b0}}, 1'b1};
    assign expired_o = enable_i && (count_inc >= {1'b0, limit_i});

    // Wait-cycle counter, cleared whenever a new request is issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_inc[Width-1:0];
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: phase strobes, memory handshake with timeout,
// single-step debug, latched trap cause and cycle/retired-instruction counters.
module core_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [6:0]  HALT_OPCODE    = 7'b1111111
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 step_mode_i,
    input  logic                 step_i,
    input  logic [6:0]           opcode_i,
    input  logic                 decode_error_i,
    input  logic                 mem_op_i,
    input  logic                 is_store_i,
    input  logic                 mem_ack_i,
    input  logic                 mem_fault_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic                 mem_sel_o,
    output logic                 ir_load_o,
    output logic                 exec_en_o,
    output logic                 wb_en_o,
    output logic                 pc_en_o,
    output logic [3:0]           state_o,
    output logic [2:0]           trap_cause_o,
    output logic                 halted_o,
    output logic [CNT_WIDTH-1:0] cycle_count_o,
    output logic [CNT_WIDTH-1:0] instret_count_o
);

    // Elaboration-time parameter sanity; counters are read back through a word-wide mux.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end
    if (CNT_WIDTH > WORD_SIZE) begin : g_bad_cnt_width
        $error("CNT_WIDTH must not exceed WORD_SIZE");
    end

    state_e      state_q, state_d;
    trap_cause_e trap_cause_q, trap_cause_d, cause_new;

    logic mem_req_q, mem_req_d;
    logic mem_we_q, mem_we_d;
    logic mem_sel_q, mem_sel_d;
    logic ir_load_q, ir_load_d;
    logic exec_en_q, exec_en_d;
    logic wb_en_q, wb_en_d;
    logic pc_en_q, pc_en_d;
    logic halted_q, halted_d;

    logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_WIDTH-1:0] instret_count_q, instret_count_d;

    logic in_wait;
    logic to_clear;
    logic to_enable;
    logic to_expired;

    assign in_wait   = (state_q == StFetchWait) || (state_q == StMemWait);
    assign to_clear  = (state_q == StFetch) || (state_q == StMem);
    // Counting stops on the ack cycle, so a same-cycle ack always beats the timeout.
    assign to_enable = in_wait && !mem_ack_i;

    mem_timeout_counter #(
        .Width(TimeoutWidth)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (to_clear),
        .enable_i (to_enable),
        .limit_i  (TimeoutWidth'(TIMEOUT_CYCLES)),
        .expired_o(to_expired)
    );

    // Next-state decode and trap-cause selection.
    always_comb begin
        state_d   = state_q;
        cause_new = CauseNone;
        case (state_q)
            StIdle:      if (start_i) state_d = StFetch;
            StFetch:     state_d = StFetchWait;
            StFetchWait: begin
                if (mem_ack_i) begin
                    if (mem_fault_i) begin
                        state_d   = StTrap;
                        cause_new = CauseMemFault;
                    end else begin
                        state_d = StDecode;
                    end
                end else if (to_expired) begin
                    state_d   = StTrap;
                    cause_new = CauseFetchTimeout;
                end
            end
            StDecode:    state_d = StExecute;
            StExecute: begin
                if (opcode_i == HALT_OPCODE) begin
                    state_d = StHalted;
                end else if (decode_error_i) begin
                    state_d   = StTrap;
                    cause_new = CauseDecode;
                end else if (mem_op_i) begin
                    state_d = StMem;
                end else begin
                    state_d = StWriteback;
                end
            end
            StMem:       state_d = StMemWait;
            StMemWait: begin
                if (mem_ack_i) begin
                    if (mem_fault_i) begin
                        state_d   = StTrap;
                        cause_new = CauseMemFault;
                    end else begin
                        state_d = StWriteback;
                    end
                end else if (to_expired) begin
                    state_d   = StTrap;
                    cause_new = CauseDataTimeout;
                end
            end
            StWriteback: state_d = step_mode_i ? StStepPause : StFetch;
            StStepPause: if (step_i || !step_mode_i) state_d = StFetch;
            StHalted:    state_d = StHalted;
            StTrap:      state_d = StTrap;
            default: begin
                state_d   = StTrap;
                cause_new = CauseIllegalState;
            end
        endcase
    end

    // Moore outputs computed from the next state so they are valid for the whole state visit.
    always_comb begin
        trap_cause_d = trap_cause_q;
        if (trap_cause_q == CauseNone && cause_new != CauseNone) begin
            trap_cause_d = cause_new;
        end
        mem_req_d = state_d inside {StFetch, StFetchWait, StMem, StMemWait};
        mem_sel_d = state_d inside {StMem, StMemWait};
        // Store direction is captured on entry to MEM and held through the wait.
        mem_we_d  = 1'b0;
        if (state_d == StMem) begin
            mem_we_d = is_store_i;
        end else if (state_d == StMemWait) begin
            mem_we_d = mem_we_q;
        end
        // The ack cycle's strobe lands in DECODE, one cycle after the ack.
        ir_load_d = (state_d == StDecode);
        exec_en_d = (state_d == StExecute);
        wb_en_d   = (state_d == StWriteback) && !(is_store_i && mem_op_i);
        pc_en_d   = (state_d == StWriteback);
        halted_d  = state_d inside {StHalted, StTrap};
    end

    // FSM state, trap cause and registered strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            trap_cause_q <= CauseNone;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_sel_q    <= 1'b0;
            ir_load_q    <= 1'b0;
            exec_en_q    <= 1'b0;
            wb_en_q      <= 1'b0;
            pc_en_q      <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            trap_cause_q <= trap_cause_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_sel_q    <= mem_sel_d;
            ir_load_q    <= ir_load_d;
            exec_en_q    <= exec_en_d;
            wb_en_q      <= wb_en_d;
            pc_en_q      <= pc_en_d;
            halted_q     <= halted_d;
        end
    end

    // Counter next values; both wrap naturally at 2^CNT_WIDTH.
    always_comb begin
        cycle_count_d   = cycle_count_q;
        instret_count_d = instret_count_q;
        if (is_active(state_d)) begin
            cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
        end
        if (state_q == StWriteback) begin
            instret_count_d = instret_count_q + CNT_WIDTH'(1);
        end
    end

    // Cycle and retired-instruction counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_count_q   <= '0;
            instret_count_q <= '0;
        end else begin
            cycle_count_q   <= cycle_count_d;
            instret_count_q <= instret_count_d;
        end
    end

    assign mem_req_o       = mem_req_q;
    assign mem_we_o        = mem_we_q;
    assign mem_sel_o       = mem_sel_q;
    assign ir_load_o       = ir_load_q;
    assign exec_en_o       = exec_en_q;
    assign wb_en_o         = wb_en_q;
    assign pc_en_o         = pc_en_q;
    assign state_o         = state_q;
    assign trap_cause_o    = trap_cause_q;
    assign halted_o        = halted_q;
    assign cycle_count_o   = cycle_count_q;
    assign instret_count_o = instret_count_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: an instruction-level model expands each
// instruction into the cycle-by-cycle state trace it must produce.
module tb_core_sequencer;

    localparam int unsigned TO = 8;

    localparam logic [3:0] SIdle = 4'd0, SFetch = 4'd1, SFetchWait = 4'd2, SDecode = 4'd3;
    localparam logic [3:0] SExec = 4'd4, SMem = 4'd5, SMemWait = 4'd6, SWb = 4'd7;
    localparam logic [3:0] SPause = 4'd8, SHalted = 4'd9, STrap = 4'd15;

    localparam int KAlu = 0, KLoad = 1, KStore = 2, KHalt = 3, KDecErr = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, step_mode = 1'b0, step = 1'b0;
    logic [6:0]  opcode = '0;
    logic        decode_error = 1'b0, mem_op = 1'b0, is_store = 1'b0;
    logic        mem_ack = 1'b0, mem_fault = 1'b0;
    logic        mem_req, mem_we, mem_sel, ir_load, exec_en, wb_en, pc_en, halted;
    logic [3:0]  state;
    logic [2:0]  trap_cause;
    logic [31:0] cycle_count, instret_count;

    always #5 clk = ~clk;

    core_sequencer #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .step_mode_i    (step_mode),
        .step_i         (step),
        .opcode_i       (opcode),
        .decode_error_i (decode_error),
        .mem_op_i       (mem_op),
        .is_store_i     (is_store),
        .mem_ack_i      (mem_ack),
        .mem_fault_i    (mem_fault),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_sel_o      (mem_sel),
        .ir_load_o      (ir_load),
        .exec_en_o      (exec_en),
        .wb_en_o        (wb_en),
        .pc_en_o        (pc_en),
        .state_o        (state),
        .trap_cause_o   (trap_cause),
        .halted_o       (halted),
        .cycle_count_o  (cycle_count),
        .instret_count_o(instret_count)
    );

    // One expected cycle: the state that must be visible, plus the inputs to drive then.
    typedef struct {
        logic [3:0] st;
        logic [2:0] cause;
        logic       start;
        logic       step;
        logic       step_mode;
        logic       ack;
        logic       fault;
        logic       dec_err;
        logic       mem_op;
        logic       is_store;
        logic [6:0] opcode;
    } cyc_t;

    cyc_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          step_no = 0;
    logic [31:0] exp_cyc = '0;
    logic [31:0] exp_ret = '0;
    logic [2:0]  cur_cause = '0;
    logic        cur_sm = 1'b0, cur_mem = 1'b0, cur_store = 1'b0;
    logic [6:0]  cur_op = '0;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic bit running(input logic [3:0] s);
        return !(s inside {SIdle, SHalted, STrap});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic check_all(input cyc_t e);
        logic [3:0] s;
        s = e.st;
        chk("state", 32'(state), 32'(s));
        chk("mem_req", 32'(mem_req), 32'(s inside {SFetch, SFetchWait, SMem, SMemWait}));
        chk("mem_sel", 32'(mem_sel), 32'(s inside {SMem, SMemWait}));
        chk("mem_we", 32'(mem_we), 32'((s inside {SMem, SMemWait}) && e.is_store));
        chk("ir_load", 32'(ir_load), 32'(s == SDecode));
        chk("exec_en", 32'(exec_en), 32'(s == SExec));
        chk("wb_en", 32'(wb_en), 32'((s == SWb) && !(e.mem_op && e.is_store)));
        chk("pc_en", 32'(pc_en), 32'(s == SWb));
        chk("halted", 32'(halted), 32'(s inside {SHalted, STrap}));
        chk("trap_cause", 32'(trap_cause), 32'(e.cause));
        chk("cycle_count", cycle_count, exp_cyc);
        chk("instret_count", instret_count, exp_ret);
    endtask

    task automatic push(input logic [3:0] st, input logic st_start, input logic ack,
                        input logic fault, input logic stp, input logic dec);
        cyc_t e;
        e.st        = st;
        e.cause     = cur_cause;
        e.start     = st_start;
        e.step      = stp;
        e.step_mode = cur_sm;
        e.ack       = ack;
        e.fault     = fault;
        e.dec_err   = dec;
        e.mem_op    = cur_mem;
        e.is_store  = cur_store;
        e.opcode    = cur_op;
        q.push_back(e);
    endtask

    // lat > 0: ack on the lat-th wait cycle; lat == 0: never acked; lat < 0: abandoned mid-wait.
    task automatic add_wait(input logic [3:0] req_st, input logic [3:0] wait_st, input int lat,
                            input logic fault, input logic [2:0] to_cause, output bit ended);
        push(req_st, rb(), 1'b0, rb(), rb(), rb());
        ended = 1'b0;
        if (lat == 0) begin
            for (int k = 0; k < int'(TO); k++) push(wait_st, rb(), 1'b0, rb(), rb(), rb());
            cur_cause = to_cause;
            ended = 1'b1;
        end else if (lat < 0) begin
            for (int k = 0; k < 3; k++) push(wait_st, rb(), 1'b0, rb(), rb(), rb());
            ended = 1'b1;
        end else begin
            for (int k = 1; k <= lat; k++) begin
                push(wait_st, rb(), k == lat, (k == lat) ? fault : rb(), rb(), rb());
            end
            if (fault) begin
                cur_cause = 3'd2;
                ended = 1'b1;
            end
        end
    endtask

    task automatic add_instr(input int kind, input int lf, input int lm, input logic ff,
                             input logic fd, input int pause, input bit clr_sm,
                             output bit ended);
        cur_mem   = (kind == KLoad) || (kind == KStore);
        cur_store = (kind == KStore) ? 1'b1 : (kind == KLoad) ? 1'b0 : rb();
        cur_op    = (kind == KHalt) ? 7'h7F : 7'($urandom_range(0, 126));
        add_wait(SFetch, SFetchWait, lf, ff, 3'd3, ended);
        if (ended) return;
        push(SDecode, rb(), 1'b0, rb(), rb(), rb());
        if (kind == KHalt) begin
            push(SExec, rb(), 1'b0, rb(), rb(), 1'b1);
            ended = 1'b1;
            return;
        end
        if (kind == KDecErr) begin
            push(SExec, rb(), 1'b0, rb(), rb(), 1'b1);
            cur_cause = 3'd1;
            ended = 1'b1;
            return;
        end
        push(SExec, rb(), 1'b0, rb(), rb(), 1'b0);
        if (cur_mem) begin
            add_wait(SMem, SMemWait, lm, fd, 3'd4, ended);
            if (ended) return;
        end
        push(SWb, rb(), 1'b0, rb(), rb(), rb());
        if (cur_sm) begin
            for (int k = 1; k <= pause; k++) begin
                if (k == pause && clr_sm) begin
                    cur_sm = 1'b0;
                    push(SPause, rb(), 1'b0, rb(), 1'b0, rb());
                end else begin
                    push(SPause, rb(), 1'b0, rb(), k == pause, rb());
                end
            end
        end
    endtask

    task automatic add_start();
        push(SIdle, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(SIdle, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(SIdle, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add_term(input int n);
        for (int k = 0; k < n; k++) begin
            push((cur_cause != 3'd0) ? STrap : SHalted, rb(), rb(), rb(), rb(), rb());
        end
    endtask

    task automatic play();
        while (q.size() > 0) begin
            cyc_t e;
            e = q.pop_front();
            @(negedge clk);
            if (running(e.st)) exp_cyc++;
            check_all(e);
            if (e.st == SWb) exp_ret++;
            start        = e.start;
            step         = e.step;
            step_mode    = e.step_mode;
            opcode       = e.opcode;
            decode_error = e.dec_err;
            mem_op       = e.mem_op;
            is_store     = e.is_store;
            mem_ack      = e.ack;
            mem_fault    = e.fault;
            step_no++;
        end
    endtask

    // Asserted mid-cycle so the return to IDLE must be asynchronous.
    task automatic do_reset();
        cyc_t e;
        #2;
        rst_n = 1'b0;
        {start, step, step_mode, opcode, decode_error, mem_op, is_store, mem_ack, mem_fault} = '0;
        exp_cyc   = '0;
        exp_ret   = '0;
        cur_cause = '0;
        cur_sm    = 1'b0;
        e = '{st: SIdle, cause: 3'd0, start: 1'b0, step: 1'b0, step_mode: 1'b0, ack: 1'b0,
              fault: 1'b0, dec_err: 1'b0, mem_op: 1'b0, is_store: 1'b0, opcode: 7'd0};
        #1;
        check_all(e);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit ended;

        // Directed ALU instruction, a random run, then HALT with decode_error also set.
        do_reset();
        add_start();
        add_instr(KAlu, 1, 0, 1'b0, 1'b0, 0, 1'b0, ended);
        add_instr(KLoad, int'(TO), int'(TO), 1'b0, 1'b0, 0, 1'b0, ended);
        for (int i = 0; i < 25; i++) begin
            add_instr($urandom_range(KAlu, KStore), $urandom_range(1, TO), $urandom_range(1, TO),
                      1'b0, 1'b0, 0, 1'b0, ended);
        end
        add_instr(KHalt, 2, 0, 1'b0, 1'b0, 0, 1'b0, ended);
        add_term(20);
        play();

        // Store with delayed ack, then a decode error trap.
        do_reset();
        add_start();
        add_instr(KStore, 1, 5, 1'b0, 1'b0, 0, 1'b0, ended);
        add_instr(KAlu, 3, 0, 1'b0, 1'b0, 0, 1'b0, ended);
        add_instr(KDecErr, 2, 0, 1'b0, 1'b0, 0, 1'b0, ended);
        add_term(5);
        play();

        // Fetch ack never arrives.
        do_reset();
        add_start();
        add_instr(KAlu, 0, 0, 1'b0, 1'b0, 0, 1'b0, ended);
        add_term(6);
        play();

        // Single-step: three paused instructions, then step_mode dropped while paused,
        // then a data-side timeout.
        do_reset();
        add_start();
        cur_sm = 1'b1;
        for (int i = 0; i < 3; i++) begin
            add_instr($urandom_range(KAlu, KStore), $urandom_range(1, 4), $urandom_range(1, 4),
                      1'b0, 1'b0, 10, 1'b0, ended);
        end
        add_instr(KAlu, 2, 0, 1'b0, 1'b0, 4, 1'b1, ended);
        add_instr(KAlu, 1, 0, 1'b0, 1'b0, 0, 1'b0, ended);
        add_instr(KLoad, 2, 0, 1'b0, 1'b0, 0, 1'b0, ended);
        add_term(5);
        play();

        // Reset during MEM_WAIT, then a data fault, then a fetch fault.
        do_reset();
        add_start();
        add_instr(KStore, 2, -1, 1'b0, 1'b0, 0, 1'b0, ended);
        play();
        do_reset();
        add_start();
        add_instr(KLoad, 2, 3, 1'b0, 1'b1, 0, 1'b0, ended);
        add_term(4);
        play();
        do_reset();
        add_start();
        add_instr(KAlu, 3, 0, 1'b1, 1'b0, 0, 1'b0, ended);
        add_term(4);
        play();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
